// File: rtl/piece_queue_pkg.sv
// Shared types and constants for the piece queue and its storage array.
package piece_queue_pkg;

    localparam int unsigned PIECE_W     = 3;
    localparam int unsigned BAG_SIZE    = 7;
    localparam int unsigned QUEUE_DEPTH = 14;

    typedef logic [PIECE_W-1:0] piece_t;

    // Code 7 is not a legal piece; it is carried through untouched if it appears.
    localparam piece_t PIECE_NONE = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } qstate_t;

endpackage

// File: rtl/piece_fifo_shift.sv
// 14-entry shift array: entry 0 is the head. A pop shifts everything down by
// one and zero-fills the top; a bag write lands 7 pieces starting at base_i,
// where base_i already accounts for a pop in the same cycle.
module piece_fifo_shift
    import piece_queue_pkg::*;
#(
    parameter int unsigned Window = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pop_i,
    input  logic                          wr_i,
    input  logic [3:0]                    base_i,
    input  logic [BAG_SIZE*PIECE_W-1:0]   bag_i,
    output piece_t [Window-1:0]           window_o
);

    piece_t [QUEUE_DEPTH-1:0] entries_q, entries_d;
    logic   [4:0]             idx;

    // Next-state: shift on pop, then overlay the bag at its base offset.
    always_comb begin
        entries_d = entries_q;
        idx       = '0;
        if (pop_i) begin
            for (int i = 0; i < int'(QUEUE_DEPTH) - 1; i++) begin
                entries_d[i] = entries_q[i+1];
            end
            entries_d[QUEUE_DEPTH-1] = '0;
        end
        if (wr_i) begin
            for (int k = 0; k < int'(BAG_SIZE); k++) begin
                idx = {1'b0, base_i} + 5'(k);
                if (idx < 5'(QUEUE_DEPTH)) begin
                    entries_d[idx[3:0]] = bag_i[k*PIECE_W +: PIECE_W];
                end
            end
        end
    end

    // Storage register; reset clears every entry so unoccupied slots read 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

    // Expose only the head plus the preview slots the parent actually uses.
    always_comb begin
        for (int j = 0; j < int'(Window); j++) begin
            window_o[j] = entries_q[j];
        end
    end

endmodule

// File: rtl/piece_queue.sv
// Piece queue: requests 7-piece bags, unpacks them into a 14-entry shift
// array and presents the head piece plus a preview window.
module piece_queue
    import piece_queue_pkg::*;
#(
    parameter int unsigned PREVIEW = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [BAG_SIZE*PIECE_W-1:0]   bag_pieces,
    input  logic                          bag_ready,
    output logic                          newbag,
    input  logic                          pop,
    output logic [PIECE_W-1:0]            piece,
    output logic                          piece_valid,
    output logic [PIECE_W*PREVIEW-1:0]    preview,
    output logic [PREVIEW-1:0]            preview_valid,
    output logic [3:0]                    count
);

    qstate_t                state_q, state_d;
    logic    [3:0]          count_q, count_d;
    logic                   bag_ready_q, bag_ready_d;
    logic                   pop_eff;
    logic                   bag_rise;
    logic                   capture;
    logic    [3:0]          base;
    piece_t  [PREVIEW:0]    window;

    assign pop_eff     = pop && (count_q != 4'd0);
    assign bag_rise    = bag_ready && !bag_ready_q;
    assign bag_ready_d = bag_ready;
    assign base        = count_q - {3'b000, pop_eff};

    // Request FSM: refill at 7 or fewer, one-cycle request, wait for a fresh rise.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: if (count_q <= 4'd7) state_d = REQ;
            REQ:  state_d = WAIT;
            WAIT: begin
                if (bag_rise) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = REQ;
        endcase
    end

    // Occupancy: pop and capture may both land in the same cycle.
    always_comb begin
        count_d = base + (capture ? 4'(BAG_SIZE) : 4'd0);
    end

    // State registers; bag_ready_q resets high so a level held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= REQ;
            count_q     <= 4'd0;
            bag_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            bag_ready_q <= bag_ready_d;
        end
    end

    // Occupancy can never exceed two bags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count_q <= 4'(QUEUE_DEPTH));
        end
    end

    piece_fifo_shift #(
        .Window (PREVIEW + 1)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .pop_i    (pop_eff),
        .wr_i     (capture),
        .base_i   (base),
        .bag_i    (bag_pieces),
        .window_o (window)
    );

    // Outputs; newbag is masked while reset is held since the FSM parks in REQ.
    always_comb begin
        newbag      = (state_q == REQ) && !reset;
        piece       = window[0];
        piece_valid = (count_q != 4'd0);
        count       = count_q;
        for (int j = 0; j < int'(PREVIEW); j++) begin
            preview[j*PIECE_W +: PIECE_W] = window[j+1];
            preview_valid[j]              = (count_q > 4'(j + 1));
        end
    end

endmodule
